// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the pipeline control and the multi-cycle
// multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [3:0]       i_aluctl;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_flush;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result;
    logic             o_dbz;

    modport master (
        output i_start, i_aluctl, i_a, i_b, i_flush,
        input  o_busy, o_done, o_result, o_dbz
    );

    modport slave (
        input  i_start, i_aluctl, i_a, i_b, i_flush,
        output o_busy, o_done, o_result, o_dbz
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider for MUL, DIV and MOD.
// Works on operand magnitudes and applies sign correction in a single FIX cycle.
module muldiv_seq #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] ALU_MUL = 4'hA,
    parameter logic [3:0] ALU_DIV = 4'hB,
    parameter logic [3:0] ALU_MOD = 4'hC
) (
    input  logic         i_clk,
    input  logic         i_rst,
    muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;
    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_MOD} op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;      // multiplicand / remainder
    logic [WIDTH-1:0] y_q, y_d;      // multiplier / quotient
    logic [WIDTH-1:0] acc_q, acc_d;  // product, or raw A for MOD by zero
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zdiv_q, zdiv_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] abs_a, abs_b, shifted;
    logic             is_md, accept;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        x_d       = x_q;
        y_d       = y_q;
        acc_d     = acc_q;
        bmag_d    = bmag_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        zdiv_d    = zdiv_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;

        abs_a   = bus.i_a[WIDTH-1] ? -bus.i_a : bus.i_a;
        abs_b   = bus.i_b[WIDTH-1] ? -bus.i_b : bus.i_b;
        shifted = {x_q[WIDTH-2:0], y_q[WIDTH-1]};
        is_md   = (bus.i_aluctl == ALU_MUL) || (bus.i_aluctl == ALU_DIV) ||
                  (bus.i_aluctl == ALU_MOD);
        accept  = bus.i_start && is_md && !bus.i_flush;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = (bus.i_aluctl == ALU_MUL) ? OP_MUL :
                                (bus.i_aluctl == ALU_DIV) ? OP_DIV : OP_MOD;
                    bmag_d    = abs_b;
                    neg_res_d = bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1];
                    neg_rem_d = bus.i_a[WIDTH-1];
                    cnt_d     = CW'(WIDTH);
                    zdiv_d    = (bus.i_aluctl != ALU_MUL) && (bus.i_b == '0);
                    if (bus.i_aluctl == ALU_MUL) begin
                        x_d   = abs_a;
                        y_d   = abs_b;
                        acc_d = '0;
                    end else begin
                        // dividend shifts out of y into the remainder x
                        x_d   = '0;
                        y_d   = abs_a;
                        acc_d = bus.i_a;
                    end
                    state_d = zdiv_d ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (bus.i_flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q == OP_MUL) begin
                        if (y_q[0]) acc_d = acc_q + x_q;
                        x_d = x_q << 1;
                        y_d = y_q >> 1;
                    end else if (shifted >= bmag_q) begin
                        x_d = shifted - bmag_q;
                        y_d = {y_q[WIDTH-2:0], 1'b1};
                    end else begin
                        x_d = shifted;
                        y_d = {y_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.i_flush) begin
                    case (op_q)
                        OP_MUL:  result_d = neg_res_q ? -acc_q : acc_q;
                        OP_DIV:  result_d = zdiv_q ? '1 : (neg_res_q ? -y_q : y_q);
                        default: result_d = zdiv_q ? acc_q : (neg_rem_q ? -x_q : x_q);
                    endcase
                    dbz_d  = zdiv_q;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MUL;
            x_q       <= '0;
            y_q       <= '0;
            acc_q     <= '0;
            bmag_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zdiv_q    <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            x_q       <= x_d;
            y_q       <= y_d;
            acc_q     <= acc_d;
            bmag_q    <= bmag_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            zdiv_q    <= zdiv_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_busy   = (state_q != S_IDLE);
    assign bus.o_done   = done_q;
    assign bus.o_result = result_q;
    assign bus.o_dbz    = dbz_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, multi-cycle corner sequences,
// and randomized ops against an arithmetic reference.
module tb_muldiv_seq;
    localparam int         W       = 32;
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_MUL = 4'hA;
    localparam logic [3:0] ALU_DIV = 4'hB;
    localparam logic [3:0] ALU_MOD = 4'hC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W), .ALU_MUL(ALU_MUL), .ALU_DIV(ALU_DIV), .ALU_MOD(ALU_MOD)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.i_start  = 1'b1;
        bus.i_aluctl = code;
        bus.i_a      = a;
        bus.i_b      = b;
        tick();
        bus.i_start  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.o_done && n < 100);
        if (!bus.o_done) begin
            total++;
            bad++;
            $display("FAIL done_timeout waited=%0d cycles", n);
        end
    endtask

    function automatic void model(input logic [3:0] code, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r, output logic d);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        d = 1'b0;
        if (code == ALU_MUL)     r = 32'(sa * sb);
        else if (b == 32'd0) begin
            d = 1'b1;
            r = (code == ALU_DIV) ? 32'hFFFF_FFFF : a;
        end
        else if (code == ALU_DIV) r = 32'(sa / sb);
        else                      r = 32'(sa % sb);
    endfunction

    // busy and done must never overlap
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (bus.o_busy && bus.o_done) begin
                bad++;
                $display("FAIL busy_done_overlap busy=%b done=%b want not both", bus.o_busy, bus.o_done);
            end
        end
    end

    initial begin
        vec_t        vt[10];
        int          n;
        int          dones;
        logic [31:0] er;
        logic        ed;
        logic [3:0]  codes[3];

        vt[0] = '{"mul_7x6",     ALU_MUL, 32'd7,        32'd6,        32'd42,       1'b0, 33};
        vt[1] = '{"mul_m3x5",    ALU_MUL, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0, 33};
        vt[2] = '{"mul_lowbits", ALU_MUL, 32'h00010000, 32'h00010000, 32'd0,        1'b0, 33};
        vt[3] = '{"div_m7_2",    ALU_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33};
        vt[4] = '{"mod_m7_2",    ALU_MOD, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33};
        vt[5] = '{"div_7_m2",    ALU_DIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33};
        vt[6] = '{"mod_7_m2",    ALU_MOD, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 33};
        vt[7] = '{"div_min_m1",  ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33};
        vt[8] = '{"mod_min_m1",  ALU_MOD, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 33};
        vt[9] = '{"div_5_0",     ALU_DIV, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1};
        codes[0] = ALU_MUL;
        codes[1] = ALU_DIV;
        codes[2] = ALU_MOD;

        bus.i_start = 1'b0; bus.i_aluctl = ALU_ADD; bus.i_a = '0; bus.i_b = '0; bus.i_flush = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_result", bus.o_result, 32'd0);
        chk("rst_dbz", 32'(bus.o_dbz), 32'd0);
        rst = 1'b0;
        tick();

        foreach (vt[i]) begin
            launch(vt[i].code, vt[i].a, vt[i].b);
            chk({vt[i].name, "_busy"}, 32'(bus.o_busy), 32'd1);
            wait_done(n);
            chk({vt[i].name, "_lat"}, 32'(n), 32'(vt[i].lat));
            chk({vt[i].name, "_res"}, bus.o_result, vt[i].res);
            chk({vt[i].name, "_dbz"}, 32'(bus.o_dbz), 32'(vt[i].dbz));
            tick();
        end

        // modulo by zero, then check result/dbz hold after done
        launch(ALU_MOD, 32'd5, 32'd0);
        wait_done(n);
        chk("mod_5_0_lat", 32'(n), 32'd1);
        chk("mod_5_0_res", bus.o_result, 32'd5);
        chk("mod_5_0_dbz", 32'(bus.o_dbz), 32'd1);
        repeat (3) tick();
        chk("hold_res", bus.o_result, 32'd5);
        chk("hold_dbz", 32'(bus.o_dbz), 32'd1);

        // non-muldiv code is ignored
        launch(ALU_ADD, 32'd1, 32'd2);
        dones = 0;
        repeat (4) begin
            if (bus.o_busy || bus.o_done) dones++;
            tick();
        end
        chk("add_ignored", 32'(dones), 32'd0);

        // second start while busy is ignored
        launch(ALU_MUL, 32'd7, 32'd6);
        repeat (4) tick();
        launch(ALU_MUL, 32'd100, 32'd100);
        wait_done(n);
        chk("busy_start_lat", 32'(n), 32'd28);
        chk("busy_start_res", bus.o_result, 32'd42);
        tick();
        chk("busy_start_noqueue", 32'(bus.o_busy), 32'd0);

        // back-to-back: start accepted in the done cycle
        launch(ALU_MUL, 32'd3, 32'd4);
        wait_done(n);
        chk("b2b_first", bus.o_result, 32'd12);
        launch(ALU_DIV, 32'd100, 32'd7);
        wait_done(n);
        chk("b2b_lat", 32'(n), 32'd33);
        chk("b2b_res", bus.o_result, 32'd14);

        // flush mid-CALC
        launch(ALU_MUL, 32'd9, 32'd9);
        repeat (9) tick();
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        chk("flush_busy", 32'(bus.o_busy), 32'd0);
        chk("flush_res", bus.o_result, 32'd14);
        dones = 0;
        repeat (40) begin
            if (bus.o_done) dones++;
            tick();
        end
        chk("flush_nodone", 32'(dones), 32'd0);
        launch(ALU_MUL, 32'd9, 32'd9);
        wait_done(n);
        chk("post_flush_res", bus.o_result, 32'd81);

        // flush in IDLE blocks the accept
        bus.i_flush = 1'b1;
        launch(ALU_MUL, 32'd2, 32'd2);
        bus.i_flush = 1'b0;
        chk("idle_flush_block", 32'(bus.o_busy), 32'd0);
        tick();

        // reset mid-CALC
        launch(ALU_MUL, 32'd5, 32'd5);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", 32'(bus.o_busy), 32'd0);
        chk("midrst_done", 32'(bus.o_done), 32'd0);
        chk("midrst_res", bus.o_result, 32'd0);
        chk("midrst_dbz", 32'(bus.o_dbz), 32'd0);
        rst = 1'b0;
        launch(ALU_MOD, 32'd23, 32'd5);
        wait_done(n);
        chk("postrst_res", bus.o_result, 32'd3);

        // randomized ops; operands scrambled while busy must have no effect
        for (int k = 0; k < 60; k++) begin
            logic [3:0]  c;
            logic [31:0] a, b;
            c = codes[$urandom_range(0, 2)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'(int'($urandom_range(0, 10)) - 5);
                2: a = 32'h80000000;
                default: ;
            endcase
            model(c, a, b, er, ed);
            launch(c, a, b);
            bus.i_a = $urandom;
            bus.i_b = $urandom;
            wait_done(n);
            chk($sformatf("rnd%0d_lat", k), 32'(n), ed ? 32'd1 : 32'd33);
            chk($sformatf("rnd%0d_res", k), bus.o_result, er);
            chk($sformatf("rnd%0d_dbz", k), 32'(bus.o_dbz), 32'(ed));
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
